// File: rtl/uart_host.sv
// uart_host: 32-bit word <-> 8N1 serial bridge, one bit per clk, TX and RX fully independent.
// Latency: TX start bit one cycle after the tx_valid/tx_ready handshake; rx_valid the cycle after byte 3's stop bit.
// Backpressure: tx_ready is low for the 40 cycles a word is on the line; the receive side cannot be stalled.
// Ports: clk, nrst (async, active-low); tx_data/tx_valid/tx_ready -> txd;
//        rxd -> rx_data/rx_valid, plus rx_eof (frame ended) and rx_err (framing error or truncated word) pulses.
module uart_host #(
  parameter int unsigned IDLE_EOF = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        txd,
  input  logic        rxd,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_eof,
  output logic        rx_err
);

  // ---------------------------------------------------------------- transmit
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t   tx_state;
  logic [31:0] tx_word;     // byte on the line is always tx_word[31:24]
  logic [2:0]  tx_bitcnt;
  logic [1:0]  tx_bytecnt;
  logic [7:0]  tx_byte;

  assign tx_byte = tx_word[31:24];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state   <= TX_IDLE;
      tx_word    <= '0;
      tx_bitcnt  <= '0;
      tx_bytecnt <= '0;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_word    <= tx_data;
            tx_bytecnt <= '0;
            txd        <= 1'b0;
            tx_ready   <= 1'b0;
            tx_state   <= TX_START;
          end
        end
        TX_START: begin
          txd       <= tx_byte[0];
          tx_bitcnt <= '0;
          tx_state  <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_bitcnt == 3'd7) begin
            txd      <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            txd       <= tx_byte[tx_bitcnt + 3'd1];
            tx_bitcnt <= tx_bitcnt + 3'd1;
          end
        end
        TX_STOP: begin
          if (tx_bytecnt == 2'd3) begin
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            // next byte starts straight after this stop bit, no idle gap
            tx_word    <= {tx_word[23:0], 8'h00};
            tx_bytecnt <= tx_bytecnt + 2'd1;
            txd        <= 1'b0;
            tx_state   <= TX_START;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- receive
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  localparam logic [7:0] EOF_CNT = 8'(IDLE_EOF);

  rx_state_t   rx_state;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bitcnt;
  logic [1:0]  rx_bytecnt;
  logic [23:0] rx_hi;       // bytes 0..2 of the word being assembled
  logic [7:0]  idle_cnt;
  logic        word_seen;   // a word completed since the last rx_eof
  logic        idle_hit;

  // true only on the cycle the idle count steps onto IDLE_EOF, so it fires once per idle stretch
  assign idle_hit = (rx_state == RX_IDLE) && rxd && (idle_cnt == EOF_CNT - 8'd1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_state   <= RX_IDLE;
      rx_shift   <= '0;
      rx_bitcnt  <= '0;
      rx_bytecnt <= '0;
      rx_hi      <= '0;
      idle_cnt   <= '0;
      word_seen  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_eof     <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;

      if (rx_state == RX_IDLE && rxd) begin
        if (idle_cnt != EOF_CNT) idle_cnt <= idle_cnt + 8'd1;
      end else begin
        idle_cnt <= '0;
      end

      case (rx_state)
        RX_IDLE: begin
          if (!rxd) begin
            rx_bitcnt <= '0;
            rx_state  <= RX_DATA;
          end else if (idle_hit) begin
            if (rx_bytecnt != 2'd0) begin
              rx_err     <= 1'b1;
              rx_bytecnt <= '0;
            end else if (word_seen) begin
              rx_eof    <= 1'b1;
              word_seen <= 1'b0;
            end
          end
        end
        RX_DATA: begin
          // LSB arrives first, so shift right and insert at the top
          rx_shift  <= {rxd, rx_shift[7:1]};
          rx_bitcnt <= rx_bitcnt + 3'd1;
          if (rx_bitcnt == 3'd7) rx_state <= RX_STOP;
        end
        RX_STOP: begin
          if (rxd) begin
            case (rx_bytecnt)
              2'd0: rx_hi[23:16] <= rx_shift;
              2'd1: rx_hi[15:8]  <= rx_shift;
              2'd2: rx_hi[7:0]   <= rx_shift;
              default: begin
                rx_data   <= {rx_hi, rx_shift};
                rx_valid  <= 1'b1;
                word_seen <= 1'b1;
              end
            endcase
            rx_bytecnt <= rx_bytecnt + 2'd1;
            rx_state   <= RX_IDLE;
          end else begin
            rx_err     <= 1'b1;
            rx_bytecnt <= '0;
            rx_state   <= RX_WAIT;
          end
        end
        RX_WAIT: begin
          // hold off until the line goes high so a stuck-low line is not read as bytes
          if (rxd) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host.sv
// Testbench for uart_host: directed words on both lines, scoreboard queues checked by a negedge monitor.
module tb_uart_host;
  localparam int IDLE_EOF = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        txd;
  logic        rxd;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_eof;
  logic        rx_err;

  uart_host #(.IDLE_EOF(IDLE_EOF)) dut (
    .clk(clk), .nrst(nrst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
    .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_eof(rx_eof), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // expected receive events: kind 0 = rx_valid (with data), 1 = rx_err, 2 = rx_eof; at < 0 means any cycle
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          at;
  } rx_exp_t;

  rx_exp_t    rxq[$];
  logic [1:0] txq[$];   // per-cycle {txd, tx_ready}; empty queue means idle (2'b11)

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic chk_rx(input int kind, input logic [31:0] d);
    rx_exp_t x;
    n_cmp++;
    if (rxq.size() == 0) begin
      n_bad++;
      $display("FAIL rx_event unexpected kind=%0d data=%h cyc=%0d", kind, d, cyc);
    end else begin
      x = rxq.pop_front();
      if (x.kind != kind || (kind == 0 && d !== x.data) || (x.at >= 0 && x.at != cyc)) begin
        n_bad++;
        $display("FAIL rx_event got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d",
                 kind, d, cyc, x.kind, x.data, x.at);
      end
    end
  endtask

  // monitor: compares the tx line every cycle and every rx pulse against the queues
  always @(negedge clk) begin
    logic [1:0] e;
    e = 2'b11;
    if (txq.size() > 0) e = txq.pop_front();
    n_cmp++;
    if ({txd, tx_ready} !== e) begin
      n_bad++;
      $display("FAIL tx_line cyc=%0d got txd=%b rdy=%b want txd=%b rdy=%b",
               cyc, txd, tx_ready, e[1], e[0]);
    end
    if (rx_valid === 1'b1) chk_rx(0, rx_data);
    if (rx_err === 1'b1)   chk_rx(1, 32'h0);
    if (rx_eof === 1'b1)   chk_rx(2, 32'h0);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // present a word, wait (bounded) for the handshake, queue the expected 41 line cycles
  task automatic tx_start(input logic [31:0] w, output int hs_cyc);
    bit         ok;
    logic [7:0] by;
    ok = 1'b0;
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    hs_cyc = cyc;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL tx_handshake got=timeout want=accept word=%h", w);
    end else begin
      for (int b = 0; b < 4; b++) begin
        by = w[31-8*b -: 8];
        txq.push_back(2'b00);
        for (int i = 0; i < 8; i++) txq.push_back({by[i], 1'b0});
        txq.push_back(2'b10);
      end
      txq.push_back(2'b11);
    end
    tx_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stopb, output int stop_cyc);
    rxd = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      @(posedge clk); #1;
    end
    rxd = stopb;
    stop_cyc = cyc;
    @(posedge clk); #1;
    rxd = 1'b1;
  endtask

  task automatic rx_word(input logic [31:0] w, output int stop_cyc);
    for (int b = 0; b < 4; b++) rx_byte(w[31-8*b -: 8], 1'b1, stop_cyc);
  endtask

  initial begin
    int h1, h2, sc;
    tx_valid = 1'b0;
    tx_data  = 32'h0;
    rxd      = 1'b1;
    nrst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_data", rx_data, 32'h0);
    chk("rst_pulses", {29'h0, rx_valid, rx_err, rx_eof}, 32'h0);
    chk("rst_txd_rdy", {30'h0, txd, tx_ready}, 32'h3);
    nrst = 1'b1;
    idle(2);

    // single word; 0x12 goes out as 0,0,1,0,0,1,0,0,0,1
    tx_start(32'h12345678, h1);
    idle(45);

    // held valid across two words: second handshake 41 cycles after the first
    tx_start(32'hA1B2C3D4, h1);
    tx_start(32'h5E6F7081, h2);
    chk("tx_b2b_handshake_gap", 32'(h2 - h1), 32'd41);
    idle(45);

    // clean word then frame end after IDLE_EOF idle cycles
    rxq.push_back('{0, 32'hDEADBEEF, -1});
    rx_word(32'hDEADBEEF, sc);
    rxq.push_back('{2, 32'h0, sc + IDLE_EOF + 1});
    idle(25);

    // framing error on byte 1, then recovery
    rxq.push_back('{1, 32'h0, -1});
    rx_byte(8'hAA, 1'b1, sc);
    rx_byte(8'h55, 1'b0, sc);
    idle(3);
    rxq.push_back('{0, 32'h00000001, -1});
    rx_word(32'h00000001, sc);
    rxq.push_back('{2, 32'h0, sc + IDLE_EOF + 1});
    idle(25);

    // truncated word: error at the idle limit, no eof; next word must start at slot 0
    rx_byte(8'hC3, 1'b1, sc);
    rx_byte(8'h3C, 1'b1, sc);
    rxq.push_back('{1, 32'h0, sc + IDLE_EOF + 1});
    idle(25);
    rxq.push_back('{0, 32'hCAFEF00D, -1});
    rx_word(32'hCAFEF00D, sc);
    rxq.push_back('{2, 32'h0, sc + IDLE_EOF + 1});
    idle(25);

    // reset with TX in byte 2 and RX in byte 1
    tx_start(32'hA5C39617, h1);
    idle(9);
    rx_byte(8'h11, 1'b1, sc);
    rxd = 1'b0; @(posedge clk); #1;
    rxd = 1'b1; @(posedge clk); #1;
    rxd = 1'b0; @(posedge clk); #1;
    rxd = 1'b1; @(posedge clk); #1;
    #2;
    nrst = 1'b0;
    txq.delete();
    rxq.delete();
    #1;
    chk("midrst_txd_rdy", {30'h0, txd, tx_ready}, 32'h3);
    chk("midrst_pulses", {29'h0, rx_valid, rx_err, rx_eof}, 32'h0);
    chk("midrst_rx_data", rx_data, 32'h0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    tx_start(32'h600DCAFE, h1);
    rxq.push_back('{0, 32'h0F1E2D3C, -1});
    rx_word(32'h0F1E2D3C, sc);
    rxq.push_back('{2, 32'h0, sc + IDLE_EOF + 1});
    idle(30);

    chk("rx_events_left", 32'(rxq.size()), 32'd0);
    chk("tx_cycles_left", 32'(txq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
